// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - set-associative cache tag controller with age-based LRU, writeback and fill handshakes
module cache_ctrl #(
    parameter int i_size = 32,
    parameter int c_size = 24,
    parameter int d_size = 6,
    parameter int a_size = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [i_size-1:0]         req_addr,
    output logic                      rsp_valid,
    output logic                      rsp_hit,
    output logic [$clog2(a_size)-1:0] rsp_way,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [i_size-1:0]         wb_addr,
    output logic                      fill_valid,
    input  logic                      fill_ready,
    output logic [i_size-1:0]         fill_addr
);
    localparam int W    = $clog2(a_size);
    localparam int IDX  = c_size - d_size - W;
    localparam int TAG  = i_size - IDX - d_size;
    localparam int SETS = 1 << IDX;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP} state_t;
    state_t state, next_state;

    logic [TAG-1:0]    tag_mem   [SETS][a_size];
    logic [a_size-1:0] valid_mem [SETS];
    logic [a_size-1:0] dirty_mem [SETS];
    logic [W-1:0]      age_mem   [SETS][a_size];

    logic           op_write, op_inv;
    logic [TAG-1:0] req_tag;
    logic [IDX-1:0] req_idx;

    logic         hit, inv_found;
    logic [W-1:0] hit_way, inv_way, lru_way, look_way, touch_way;
    logic [W-1:0] new_age [a_size];

    logic addr_unused;
    assign addr_unused = ^req_addr[d_size-1:0];

    // Scan from the top way down so the lowest matching index wins.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int i = a_size - 1; i >= 0; i--) begin
            if (valid_mem[req_idx][W'(i)] && tag_mem[req_idx][W'(i)] == req_tag) begin
                hit     = 1'b1;
                hit_way = W'(i);
            end
            if (!valid_mem[req_idx][W'(i)]) begin
                inv_found = 1'b1;
                inv_way   = W'(i);
            end
            if (age_mem[req_idx][W'(i)] == W'(a_size - 1)) begin
                lru_way = W'(i);
            end
        end
        look_way = hit ? hit_way : (inv_found ? inv_way : lru_way);
    end

    // Touched way becomes youngest; only ways younger than it age by one.
    always_comb begin
        touch_way = (state == FILL) ? rsp_way : hit_way;
        for (int i = 0; i < a_size; i++) begin
            if (W'(i) == touch_way) begin
                new_age[W'(i)] = '0;
            end else if (age_mem[req_idx][W'(i)] < age_mem[req_idx][touch_way]) begin
                new_age[W'(i)] = age_mem[req_idx][W'(i)] + 1'b1;
            end else begin
                new_age[W'(i)] = age_mem[req_idx][W'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (req_valid && req_ready) next_state = LOOKUP;
            LOOKUP: begin
                if (op_inv) begin
                    next_state = (hit && dirty_mem[req_idx][hit_way]) ? WB : RESP;
                end else if (hit) begin
                    next_state = RESP;
                end else if (valid_mem[req_idx][look_way] && dirty_mem[req_idx][look_way]) begin
                    next_state = WB;
                end else begin
                    next_state = FILL;
                end
            end
            WB:     if (wb_ready) next_state = op_inv ? RESP : FILL;
            FILL:   if (fill_ready) next_state = RESP;
            RESP:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE) && !rst;
        rsp_valid  = (state == RESP);
        wb_valid   = (state == WB);
        fill_valid = (state == FILL);
    end

    always_ff @(posedge clk) begin
        if (!rst && state == FILL && fill_ready) begin
            tag_mem[req_idx][rsp_way] <= req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[IDX'(s)] <= '0;
                dirty_mem[IDX'(s)] <= '0;
                for (int i = 0; i < a_size; i++) begin
                    age_mem[IDX'(s)][W'(i)] <= W'(i);
                end
            end
            op_write  <= 1'b0;
            op_inv    <= 1'b0;
            req_tag   <= '0;
            req_idx   <= '0;
            rsp_hit   <= 1'b0;
            rsp_way   <= '0;
            wb_addr   <= '0;
            fill_addr <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op_write <= (req_op == 2'd1);
                    op_inv   <= (req_op == 2'd2);
                    req_tag  <= req_addr[i_size-1 -: TAG];
                    req_idx  <= req_addr[d_size +: IDX];
                end
                LOOKUP: begin
                    rsp_hit   <= hit;
                    rsp_way   <= (op_inv && !hit) ? '0 : look_way;
                    wb_addr   <= {tag_mem[req_idx][look_way], req_idx, {d_size{1'b0}}};
                    fill_addr <= {req_tag, req_idx, {d_size{1'b0}}};
                    if (hit && !op_inv) begin
                        for (int i = 0; i < a_size; i++) begin
                            age_mem[req_idx][W'(i)] <= new_age[W'(i)];
                        end
                        if (op_write) dirty_mem[req_idx][hit_way] <= 1'b1;
                    end
                    if (hit && op_inv && !dirty_mem[req_idx][hit_way]) begin
                        valid_mem[req_idx][hit_way] <= 1'b0;
                    end
                end
                WB: if (wb_ready) begin
                    valid_mem[req_idx][rsp_way] <= 1'b0;
                    dirty_mem[req_idx][rsp_way] <= 1'b0;
                end
                FILL: if (fill_ready) begin
                    valid_mem[req_idx][rsp_way] <= 1'b1;
                    dirty_mem[req_idx][rsp_way] <= op_write;
                    for (int i = 0; i < a_size; i++) begin
                        age_mem[req_idx][W'(i)] <= new_age[W'(i)];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - directed bench for cache_ctrl checked against a recency-list cache model
module tb_cache_ctrl;
    logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, wb_ready = 1'b0, fill_ready = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [15:0] req_addr = 16'h0;
    logic        req_ready, rsp_valid, rsp_hit, wb_valid, fill_valid;
    logic [1:0]  rsp_way;
    logic [15:0] wb_addr, fill_addr;

    cache_ctrl #(.i_size(16), .c_size(10), .d_size(4), .a_size(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Model: per set a recency list of ways (front = most recent) plus tag/valid/dirty.
    int          order   [16][$];
    logic [7:0]  m_tag   [16][4];
    bit          m_valid [16][4];
    bit          m_dirty [16][4];

    bit          busy = 1'b0, exp_hit, exp_wb, exp_fill;
    int          exp_way, exp_lat, acc;
    logic [15:0] exp_wb_addr, exp_fill_addr;
    bit          got_hit, got_wb, got_fill;
    int          got_way, got_lat, got_wb_cycles;
    logic [15:0] got_wb_addr, got_fill_addr;

    function automatic void model_reset();
        for (int s = 0; s < 16; s++) begin
            order[s].delete();
            for (int w = 0; w < 4; w++) begin
                order[s].push_back(w);
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endfunction

    function automatic void model_touch(input int s, input int w);
        for (int k = 0; k < order[s].size(); k++) begin
            if (order[s][k] == w) begin
                order[s].delete(k);
                break;
            end
        end
        order[s].push_front(w);
    endfunction

    function automatic void model_req(input logic [1:0] op, input logic [15:0] addr, input int stall);
        int         s   = int'(addr[7:4]);
        logic [7:0] t   = addr[15:8];
        int         hw  = -1;
        int         v   = -1;
        int         nhs = (stall < 0) ? 1 : stall + 1;
        for (int w = 3; w >= 0; w--) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
        exp_wb = 1'b0; exp_fill = 1'b0; exp_hit = (hw >= 0); exp_way = 0;
        exp_wb_addr = 16'h0; exp_fill_addr = 16'h0;
        if (op == 2'd2) begin
            if (hw >= 0) begin
                exp_way = hw;
                if (m_dirty[s][hw]) begin
                    exp_wb = 1'b1;
                    exp_wb_addr = {t, 4'(s), 4'h0};
                end
                m_valid[s][hw] = 1'b0;
                m_dirty[s][hw] = 1'b0;
            end
        end else if (hw >= 0) begin
            exp_way = hw;
            model_touch(s, hw);
            if (op == 2'd1) m_dirty[s][hw] = 1'b1;
        end else begin
            for (int w = 3; w >= 0; w--) if (!m_valid[s][w]) v = w;
            if (v < 0) v = order[s][order[s].size() - 1];
            exp_way = v;
            if (m_valid[s][v] && m_dirty[s][v]) begin
                exp_wb = 1'b1;
                exp_wb_addr = {m_tag[s][v], 4'(s), 4'h0};
            end
            exp_fill = 1'b1;
            exp_fill_addr = {t, 4'(s), 4'h0};
            m_tag[s][v] = t;
            m_valid[s][v] = 1'b1;
            m_dirty[s][v] = (op == 2'd1);
            model_touch(s, v);
        end
        exp_lat = 2 + (exp_wb ? nhs : 0) + (exp_fill ? nhs : 0);
    endfunction

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("wb_fill_exclusive", 32'(wb_valid && fill_valid), 0);
            if (busy) begin
                check_eq("req_ready_busy", 32'(req_ready), 0);
                if (wb_valid) check_eq("wb_addr", 32'(wb_addr), 32'(exp_wb_addr));
                if (fill_valid) check_eq("fill_addr", 32'(fill_addr), 32'(exp_fill_addr));
                if (rsp_valid) begin
                    check_eq("rsp_hit", 32'(rsp_hit), 32'(exp_hit));
                    check_eq("rsp_way", 32'(rsp_way), 32'(exp_way));
                    check_eq("rsp_latency", 32'(cyc - acc + 1), 32'(exp_lat));
                end
            end else begin
                check_eq("idle_outputs", 32'({rsp_valid, wb_valid, fill_valid}), 0);
                check_eq("req_ready_idle", 32'(req_ready), 1);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [15:0] addr);
        bit ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_addr = addr;
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = req_ready;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!ok) check_eq("accept_timeout", 0, 1);
        else begin
            acc  = cyc;
            busy = 1'b1;
        end
    endtask

    // stall < 0: ready held high before the handshake state is entered.
    task automatic complete(input int stall);
        int wc = 0, fc = 0;
        bit done = 1'b0;
        got_wb = 1'b0; got_fill = 1'b0; got_wb_cycles = 0;
        wb_ready = (stall < 0); fill_ready = (stall < 0);
        for (int k = 0; k < 200 && busy && !done; k++) begin
            @(posedge clk); #1;
            if (wb_valid) begin
                got_wb = 1'b1; got_wb_addr = wb_addr; got_wb_cycles++;
                wb_ready = (stall < 0) || (wc == stall);
                wc++;
            end else wb_ready = (stall < 0);
            if (fill_valid) begin
                got_fill = 1'b1; got_fill_addr = fill_addr;
                fill_ready = (stall < 0) || (fc == stall);
                fc++;
            end else fill_ready = (stall < 0);
            if (rsp_valid) begin
                got_hit = rsp_hit; got_way = rsp_way; got_lat = cyc - acc + 1;
                done = 1'b1;
            end
        end
        if (!done) check_eq("rsp_timeout", 0, 1);
        @(posedge clk); #1;
        busy = 1'b0; wb_ready = 1'b0; fill_ready = 1'b0;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [15:0] addr, input int stall);
        model_req(op, addr, stall);
        issue(op, addr);
        complete(stall);
        check_eq("wb_seen", 32'(got_wb), 32'(exp_wb));
        check_eq("fill_seen", 32'(got_fill), 32'(exp_fill));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 0);
        check_eq("rst_valids", 32'({rsp_valid, wb_valid, fill_valid}), 0);
        check_eq("rst_rsp", 32'({rsp_hit, rsp_way}), 0);
        check_eq("rst_wb_addr", 32'(wb_addr), 0);
        check_eq("rst_fill_addr", 32'(fill_addr), 0);
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", 32'(req_ready), 1);

        do_req(2'd0, 16'h1234, 0);
        check_eq("r1_wb", 32'(got_wb), 0);
        check_eq("r1_fill_addr", 32'(got_fill_addr), 32'h1230);
        check_eq("r1_hit", 32'(got_hit), 0);
        check_eq("r1_way", 32'(got_way), 0);
        do_req(2'd0, 16'h1238, 0);
        check_eq("r2_hit", 32'(got_hit), 1);
        check_eq("r2_way", 32'(got_way), 0);
        check_eq("r2_lat", 32'(got_lat), 2);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_req(2'd0, 16'h1030 + 16'(i * 16'h100), 0);
            check_eq("s3_fill_way", 32'(got_way), 32'(i));
        end
        do_req(2'd1, 16'h1030, 0);
        do_req(2'd0, 16'h1130, -1);
        do_req(2'd0, 16'h1230, -1);
        do_req(2'd0, 16'h1330, -1);
        do_req(2'd0, 16'h1430, 5);
        check_eq("evict_wb_addr", 32'(got_wb_addr), 32'h1030);
        check_eq("evict_wb_cycles", 32'(got_wb_cycles), 6);
        check_eq("evict_fill_addr", 32'(got_fill_addr), 32'h1430);
        check_eq("evict_hit", 32'(got_hit), 0);
        check_eq("evict_way", 32'(got_way), 0);

        do_req(2'd2, 16'h1130, 0);
        check_eq("inv_clean_hit", 32'(got_hit), 1);
        check_eq("inv_clean_way", 32'(got_way), 1);
        check_eq("inv_clean_wb", 32'(got_wb), 0);
        do_req(2'd0, 16'h1130, 0);
        check_eq("reread_hit", 32'(got_hit), 0);
        check_eq("reread_way", 32'(got_way), 1);
        do_req(2'd2, 16'h7F00, 0);
        check_eq("inv_miss_hit", 32'(got_hit), 0);
        check_eq("inv_miss_way", 32'(got_way), 0);

        do_req(2'd1, 16'h1230, -1);
        do_req(2'd2, 16'h1230, -1);
        check_eq("inv_dirty_wb_addr", 32'(got_wb_addr), 32'h1230);
        check_eq("inv_dirty_way", 32'(got_way), 2);
        check_eq("inv_dirty_fill", 32'(got_fill), 0);
        do_req(2'd3, 16'h1438, 0);
        check_eq("op3_read_hit", 32'(got_hit), 1);

        for (int i = 0; i < 16; i++) begin
            do_req((i % 3 == 1) ? 2'd1 : 2'd0, 16'({8'((i * 5) % 7), 8'h60}), (i % 4 == 0) ? -1 : i % 3);
        end

        model_req(2'd0, 16'h5550, 0);
        issue(2'd0, 16'h5550);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(posedge clk); #1;
                seen = fill_valid;
            end
            check_eq("abort_fill_seen", 32'(seen), 1);
        end
        rst = 1'b1;
        busy = 1'b0;
        @(posedge clk); #1;
        check_eq("abort_fill_cleared", 32'(fill_valid), 0);
        check_eq("abort_ready_in_rst", 32'(req_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        #1;
        check_eq("abort_ready", 32'(req_ready), 1);
        do_req(2'd0, 16'h5550, 0);
        check_eq("abort_reread_miss", 32'(got_hit), 0);
        do_req(2'd0, 16'h1438, 0);
        check_eq("prior_reread_miss", 32'(got_hit), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
